// File: rtl/missile_pkg.sv
// Shared types and screen constants for the missile life-cycle controller
// and its bitmap offset rotator.
package missile_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } missile_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    // Centres the 25-pixel missile on the 32-pixel tank side.
    localparam int SPAWN_C  = (32 - 25) / 2;

endpackage

// File: rtl/missile_offset_rotator.sv
// Maps the in-box pixel offset onto the right-facing bitmap so one ROM image
// serves all four flight directions.
module missile_offset_rotator
    import missile_pkg::*;
#(
    parameter int OBJECT_WIDTH_X = 25
) (
    input  logic [10:0] dx,
    input  logic [10:0] dy,
    input  dir_t        dir,
    output logic [10:0] offset_x,
    output logic [10:0] offset_y
);

    localparam logic [10:0] N = 11'(OBJECT_WIDTH_X - 1);

    always_comb begin
        offset_x = dx;
        offset_y = dy;
        case (dir)
            DIR_RIGHT: begin
                offset_x = dx;
                offset_y = dy;
            end
            DIR_LEFT: begin
                offset_x = N - dx;
                offset_y = dy;
            end
            DIR_UP: begin
                offset_x = N - dy;
                offset_y = dx;
            end
            DIR_DOWN: begin
                offset_x = dy;
                offset_y = N - dx;
            end
            default: begin
                offset_x = dx;
                offset_y = dy;
            end
        endcase
    end

endmodule

// File: rtl/missile_controller.sv
// Missile life cycle (fire, flight, death, cooldown) plus the registered
// per-pixel hit/offset signals consumed by the bitmap ROM stage.
module missile_controller #(
    parameter int OBJECT_WIDTH_X  = 25,
    parameter int OBJECT_HEIGHT_Y = 25,
    parameter int TANK_SIZE       = 32,
    parameter int SPEED           = 4,
    parameter int SCREEN_W        = missile_pkg::SCREEN_W,
    parameter int SCREEN_H        = missile_pkg::SCREEN_H,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        fire,
    input  logic [10:0] tankX,
    input  logic [10:0] tankY,
    input  logic [1:0]  tankDir,
    input  logic        collision,
    output logic        missileActive,
    output logic [10:0] missileX,
    output logic [10:0] missileY,
    output logic [1:0]  missileDir,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY
);
    import missile_pkg::*;

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic signed [11:0] W_S     = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] H_S     = 12'(OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] TANK_S  = 12'(TANK_SIZE);
    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic signed [11:0] C_S     = 12'((TANK_SIZE - OBJECT_WIDTH_X) / 2);

    missile_state_t    state, state_nx;
    dir_t              dir_q, dir_nx;
    logic signed [11:0] pos_x, pos_y, pos_x_nx, pos_y_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              active_q;
    logic signed [11:0] tank_x_s, tank_y_s, spawn_x, spawn_y, move_x, move_y;
    logic signed [11:0] dx, dy;
    logic              hit;
    logic [10:0]       rot_x, rot_y;
    logic              inside_p1;
    logic [10:0]       offset_x_p1, offset_y_p1;

    function automatic logic box_on_screen(input logic signed [11:0] x,
                                           input logic signed [11:0] y);
        box_on_screen = (x >= 0) && (int'(x) + OBJECT_WIDTH_X <= SCREEN_W) &&
                        (y >= 0) && (int'(y) + OBJECT_HEIGHT_Y <= SCREEN_H);
    endfunction

    assign tank_x_s = signed'({1'b0, tankX});
    assign tank_y_s = signed'({1'b0, tankY});

    always_comb begin
        spawn_x = tank_x_s + C_S;
        spawn_y = tank_y_s - H_S;
        case (dir_t'(tankDir))
            DIR_UP:    begin spawn_x = tank_x_s + C_S;    spawn_y = tank_y_s - H_S;    end
            DIR_RIGHT: begin spawn_x = tank_x_s + TANK_S; spawn_y = tank_y_s + C_S;    end
            DIR_DOWN:  begin spawn_x = tank_x_s + C_S;    spawn_y = tank_y_s + TANK_S; end
            DIR_LEFT:  begin spawn_x = tank_x_s - W_S;    spawn_y = tank_y_s + C_S;    end
            default:   begin spawn_x = tank_x_s + C_S;    spawn_y = tank_y_s - H_S;    end
        endcase
    end

    always_comb begin
        move_x = pos_x;
        move_y = pos_y;
        case (dir_q)
            DIR_UP:    move_y = pos_y - SPEED_S;
            DIR_RIGHT: move_x = pos_x + SPEED_S;
            DIR_DOWN:  move_y = pos_y + SPEED_S;
            DIR_LEFT:  move_x = pos_x - SPEED_S;
            default:   move_x = pos_x;
        endcase
    end

    // Collision wins over a same-cycle frame tick; a blocked move kills the missile in place.
    always_comb begin
        state_nx = state;
        pos_x_nx = pos_x;
        pos_y_nx = pos_y;
        dir_nx   = dir_q;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (fire && box_on_screen(spawn_x, spawn_y)) begin
                    state_nx = ST_FLYING;
                    pos_x_nx = spawn_x;
                    pos_y_nx = spawn_y;
                    dir_nx   = dir_t'(tankDir);
                end
            end
            ST_FLYING: begin
                if (collision) begin
                    state_nx = ST_COOLDOWN;
                    cnt_nx   = '0;
                end else if (startOfFrame) begin
                    if (box_on_screen(move_x, move_y)) begin
                        pos_x_nx = move_x;
                        pos_y_nx = move_y;
                    end else begin
                        state_nx = ST_COOLDOWN;
                        cnt_nx   = '0;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (startOfFrame) begin
                    if (cnt == CNT_LAST) state_nx = ST_IDLE;
                    else                 cnt_nx   = cnt + CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pos_x    <= '0;
            pos_y    <= '0;
            dir_q    <= DIR_UP;
            cnt      <= '0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nx;
            pos_x    <= pos_x_nx;
            pos_y    <= pos_y_nx;
            dir_q    <= dir_nx;
            cnt      <= cnt_nx;
            active_q <= (state_nx == ST_FLYING);
        end
    end

    assign dx  = signed'({1'b0, pixelX}) - pos_x;
    assign dy  = signed'({1'b0, pixelY}) - pos_y;
    assign hit = (state == ST_FLYING) && (dx >= 0) && (dx < W_S) && (dy >= 0) && (dy < H_S);

    missile_offset_rotator #(
        .OBJECT_WIDTH_X(OBJECT_WIDTH_X)
    ) u_rotator (
        .dx      (dx[10:0]),
        .dy      (dy[10:0]),
        .dir     (dir_q),
        .offset_x(rot_x),
        .offset_y(rot_y)
    );

    // Render stage p1: one clock after pixelX/pixelY.
    always_ff @(posedge clk) begin
        if (reset) begin
            inside_p1   <= 1'b0;
            offset_x_p1 <= '0;
            offset_y_p1 <= '0;
        end else begin
            inside_p1   <= hit;
            offset_x_p1 <= hit ? rot_x : 11'd0;
            offset_y_p1 <= hit ? rot_y : 11'd0;
        end
    end

    assign missileActive   = active_q;
    assign missileX        = pos_x[10:0];
    assign missileY        = pos_y[10:0];
    assign missileDir      = dir_q;
    assign InsideRectangle = inside_p1;
    assign offsetX         = offset_x_p1;
    assign offsetY         = offset_y_p1;

endmodule

// File: tb/tb_missile_controller.sv
// Directed scenarios plus a randomized run of the missile controller against
// a frame-level behavioural model.
module tb_missile_controller;

    localparam int W = 25;
    localparam int H = 25;
    localparam int TS = 32;
    localparam int CC = 3;
    localparam int SPD = 4;
    localparam int SW = 640;
    localparam int SH = 480;
    localparam int CDF = 8;
    localparam int MS_IDLE = 0, MS_FLY = 1, MS_CD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        fire = 1'b0;
    logic [10:0] tankX = '0, tankY = '0;
    logic [1:0]  tankDir = '0;
    logic        collision = 1'b0;
    logic        missileActive;
    logic [10:0] missileX, missileY;
    logic [1:0]  missileDir;
    logic        InsideRectangle;
    logic [10:0] offsetX, offsetY;

    int n_checks = 0;
    int n_fail = 0;

    int m_state = MS_IDLE, m_x = 0, m_y = 0, m_dir = 0, m_frames = 0;
    bit m_in = 0;
    int m_ox = 0, m_oy = 0;

    missile_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .fire(fire),
        .tankX(tankX), .tankY(tankY), .tankDir(tankDir), .collision(collision),
        .missileActive(missileActive), .missileX(missileX), .missileY(missileY),
        .missileDir(missileDir), .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY)
    );

    always #5 clk = ~clk;

    function automatic bit on_screen(input int x, input int y);
        return (x >= 0) && (x + W <= SW) && (y >= 0) && (y + H <= SH);
    endfunction

    // Model: whole-frame rules, advanced once per clock from pre-edge inputs.
    task automatic cycle();
        int dx, dy, sx, sy, nx, ny, ox, oy;
        bit hit;
        dx = int'(pixelX) - m_x;
        dy = int'(pixelY) - m_y;
        hit = (m_state == MS_FLY) && dx >= 0 && dx < W && dy >= 0 && dy < H;
        ox = 0; oy = 0;
        if (hit) begin
            case (m_dir)
                0: begin ox = (W - 1) - dy; oy = dx; end
                1: begin ox = dx; oy = dy; end
                2: begin ox = dy; oy = (W - 1) - dx; end
                default: begin ox = (W - 1) - dx; oy = dy; end
            endcase
        end
        if (reset) begin
            m_state = MS_IDLE; m_x = 0; m_y = 0; m_dir = 0; m_frames = 0;
            m_in = 0; m_ox = 0; m_oy = 0;
        end else begin
            m_in = hit; m_ox = ox; m_oy = oy;
            case (m_state)
                MS_IDLE: if (fire) begin
                    case (int'(tankDir))
                        0: begin sx = int'(tankX) + CC; sy = int'(tankY) - H; end
                        1: begin sx = int'(tankX) + TS; sy = int'(tankY) + CC; end
                        2: begin sx = int'(tankX) + CC; sy = int'(tankY) + TS; end
                        default: begin sx = int'(tankX) - W; sy = int'(tankY) + CC; end
                    endcase
                    if (on_screen(sx, sy)) begin
                        m_state = MS_FLY; m_x = sx; m_y = sy; m_dir = int'(tankDir);
                    end
                end
                MS_FLY: begin
                    if (collision) begin
                        m_state = MS_CD; m_frames = 0;
                    end else if (startOfFrame) begin
                        nx = m_x + ((m_dir == 1) ? SPD : (m_dir == 3) ? -SPD : 0);
                        ny = m_y + ((m_dir == 2) ? SPD : (m_dir == 0) ? -SPD : 0);
                        if (on_screen(nx, ny)) begin m_x = nx; m_y = ny; end
                        else begin m_state = MS_CD; m_frames = 0; end
                    end
                end
                default: if (startOfFrame) begin
                    m_frames++;
                    if (m_frames == CDF) m_state = MS_IDLE;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fire = 0; collision = 0; startOfFrame = 0; pixelX = 0; pixelY = 0;
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic launch(input int tx, input int ty, input int d);
        tankX = 11'(tx); tankY = 11'(ty); tankDir = 2'(d);
        fire = 1;
        cycle();
        fire = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        n_checks++; if (missileActive !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", missileActive); end
        n_checks++; if (missileX !== 11'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", missileX); end
        n_checks++; if (missileY !== 11'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", missileY); end
        n_checks++; if (missileDir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got %0d want 0", missileDir); end
        n_checks++; if (InsideRectangle !== 1'b0) begin n_fail++; $display("FAIL reset_inside got %b want 0", InsideRectangle); end
        n_checks++; if ({offsetX, offsetY} !== 22'd0) begin n_fail++; $display("FAIL reset_offsets got %0d,%0d want 0,0", offsetX, offsetY); end
        launch(100, 200, 1);
        pixelX = 11'd137; pixelY = 11'd205;
        cycle();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd5, 11'd2}) begin
            n_fail++; $display("FAIL preflight_render got %b/%0d/%0d want 1/5/2", InsideRectangle, offsetX, offsetY); end
        reset = 1;
        cycle();
        reset = 0;
        n_checks++; if (missileActive !== 1'b0) begin n_fail++; $display("FAIL midflight_reset_active got %b want 0", missileActive); end
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== 23'd0) begin
            n_fail++; $display("FAIL midflight_reset_render got %b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
        fire = 1;
        cycle();
        fire = 0;
        n_checks++; if ({missileActive, missileX, missileY} !== {1'b1, 11'd132, 11'd203}) begin
            n_fail++; $display("FAIL respawn_after_reset got %b/%0d/%0d want 1/132/203", missileActive, missileX, missileY); end
    endtask

    task automatic test_spawn_right();
        do_reset();
        launch(100, 200, 1);
        n_checks++; if ({missileActive, missileX, missileY, missileDir} !== {1'b1, 11'd132, 11'd203, 2'd1}) begin
            n_fail++; $display("FAIL spawn_right got %b/%0d/%0d/%0d want 1/132/203/1", missileActive, missileX, missileY, missileDir); end
        for (int k = 0; k < 3; k++) begin
            startOfFrame = 1; cycle();
            startOfFrame = 0; cycle();
        end
        n_checks++; if ({missileX, missileY} !== {11'd144, 11'd203}) begin
            n_fail++; $display("FAIL move_right got %0d,%0d want 144,203", missileX, missileY); end
    endtask

    task automatic test_rotation();
        do_reset();
        launch(297, 125, 0);
        n_checks++; if ({missileActive, missileX, missileY, missileDir} !== {1'b1, 11'd300, 11'd100, 2'd0}) begin
            n_fail++; $display("FAIL spawn_up got %b/%0d/%0d/%0d want 1/300/100/0", missileActive, missileX, missileY, missileDir); end
        pixelX = 11'd300; pixelY = 11'd124; cycle();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd0, 11'd0}) begin
            n_fail++; $display("FAIL rot_up_bl got %b/%0d/%0d want 1/0/0", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd324; pixelY = 11'd100; cycle();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd24, 11'd24}) begin
            n_fail++; $display("FAIL rot_up_tr got %b/%0d/%0d want 1/24/24", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd300; pixelY = 11'd100; cycle();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd24, 11'd0}) begin
            n_fail++; $display("FAIL rot_up_tl got %b/%0d/%0d want 1/24/0", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd325; pixelY = 11'd100; cycle();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== 23'd0) begin
            n_fail++; $display("FAIL rot_up_outside got %b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
    endtask

    task automatic test_screen_edge();
        do_reset();
        launch(580, 100, 1);
        n_checks++; if ({missileActive, missileX} !== {1'b1, 11'd612}) begin
            n_fail++; $display("FAIL edge_spawn got %b/%0d want 1/612", missileActive, missileX); end
        startOfFrame = 1; cycle();
        n_checks++; if ({missileActive, missileX} !== {1'b0, 11'd612}) begin
            n_fail++; $display("FAIL edge_kill got %b/%0d want 0/612", missileActive, missileX); end
        fire = 1;
        for (int k = 0; k < CDF; k++) begin
            cycle();
            n_checks++; if (missileActive !== 1'b0) begin
                n_fail++; $display("FAIL cooldown_frame%0d active got %b want 0", k + 1, missileActive); end
        end
        startOfFrame = 0;
        cycle();
        fire = 0;
        n_checks++; if ({missileActive, missileX} !== {1'b1, 11'd612}) begin
            n_fail++; $display("FAIL fire_after_cooldown got %b/%0d want 1/612", missileActive, missileX); end
    endtask

    task automatic test_collision();
        do_reset();
        launch(168, 100, 1);
        collision = 1; startOfFrame = 1; cycle();
        collision = 0; startOfFrame = 0;
        n_checks++; if ({missileActive, missileX} !== {1'b0, 11'd200}) begin
            n_fail++; $display("FAIL collision_kill got %b/%0d want 0/200", missileActive, missileX); end
        fire = 1; cycle(); fire = 0;
        n_checks++; if (missileActive !== 1'b0) begin
            n_fail++; $display("FAIL cooldown_fire got %b want 0", missileActive); end
    endtask

    task automatic test_offscreen_spawn();
        do_reset();
        tankX = 11'd100; tankY = 11'd10; tankDir = 2'd0; fire = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (missileActive !== 1'b0) begin
                n_fail++; $display("FAIL offscreen_up got %b want 0", missileActive); end
        end
        tankX = 11'd20; tankY = 11'd100; tankDir = 2'd3; cycle();
        n_checks++; if (missileActive !== 1'b0) begin
            n_fail++; $display("FAIL offscreen_left got %b want 0", missileActive); end
        tankX = 11'd100; tankY = 11'd25; tankDir = 2'd0; cycle();
        fire = 0;
        n_checks++; if ({missileActive, missileY} !== {1'b1, 11'd0}) begin
            n_fail++; $display("FAIL spawn_at_top got %b/%0d want 1/0", missileActive, missileY); end
    endtask

    task automatic test_random();
        int px, py;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            startOfFrame = ($urandom_range(0, 9) == 0);
            fire         = ($urandom_range(0, 3) == 0);
            collision    = ($urandom_range(0, 59) == 0);
            tankX   = 11'($urandom_range(0, 640));
            tankY   = 11'($urandom_range(0, 480));
            tankDir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                px = m_x + int'($urandom_range(0, 29)) - 2;
                py = m_y + int'($urandom_range(0, 29)) - 2;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
            end else begin
                px = int'($urandom_range(0, 799));
                py = int'($urandom_range(0, 524));
            end
            pixelX = 11'(px); pixelY = 11'(py);
            cycle();
            n_checks++;
            if ({missileActive, missileX, missileY, missileDir} !==
                {(m_state == MS_FLY), 11'(m_x), 11'(m_y), 2'(m_dir)}) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", i,
                         missileActive, missileX, missileY, missileDir,
                         (m_state == MS_FLY), m_x, m_y, m_dir);
            end
            n_checks++;
            if ({InsideRectangle, offsetX, offsetY} !== {m_in, 11'(m_ox), 11'(m_oy)}) begin
                n_fail++;
                $display("FAIL rand_render cyc %0d got %b/%0d/%0d want %b/%0d/%0d", i,
                         InsideRectangle, offsetX, offsetY, m_in, m_ox, m_oy);
            end
        end
        reset = 0; fire = 0; collision = 0; startOfFrame = 0;
    endtask

    initial begin
        test_reset();
        test_spawn_right();
        test_rotation();
        test_screen_edge();
        test_collision();
        test_offscreen_spawn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
